dbuf_swap_ctrl: RTL
===================

Name: dbuf_swap_ctrl

Overview:
- Sequencer for the graphics-side port of the double-buffered frame store.
- Owns the buffer-select `toggle` and the back-buffer write port (`buf_addr`/`buf_din`/`buf_we`).
- Arbitrates that port between the renderer pixel stream and an internal backdrop clear engine.
- Swaps buffers only at VGA frame end after the renderer reports its frame complete, so VGA never scans a half-drawn frame.

Parameters:
- PIX_COUNT, 38400, pixels per frame (240x160); valid addresses are 0..PIX_COUNT-1.
- ADDR_W, 17, width of the buffer address.
- COLOR_W, 15, width of a BGR555 pixel.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_b  in  1  reset, synchronous, active-low.
- rend_valid  in  1  renderer pixel valid.
- rend_addr  in  ADDR_W  renderer pixel address.
- rend_color  in  COLOR_W  renderer pixel color.
- rend_ready  out  1  pixel accepted when rend_valid & rend_ready.
- rend_frame_done  in  1  one-cycle pulse: renderer finished the current frame.
- render_go  out  1  one-cycle pulse: renderer may start a new frame.
- vga_frame_end  in  1  one-cycle pulse at the end of VGA active scan (clk domain).
- clear_en  in  1  enables the backdrop clear before each render.
- backdrop  in  COLOR_W  clear color.
- buf_addr  out  ADDR_W  back-buffer write address.
- buf_din  out  COLOR_W  back-buffer write data.
- buf_we  out  1  back-buffer write strobe.
- toggle  out  1  level; 0 = VGA reads buf0 and graphics writes buf1; 1 = the reverse.
- drop_cnt  out  8  saturating count of missed swaps.
- oob_err  out  1  sticky: a renderer address >= PIX_COUNT was seen.

Behaviour:
- Reset (rst_b=0 at a clk edge):
  - state=START, toggle=0, drop_cnt=0, oob_err=0.
  - buf_we=0, buf_addr=0, buf_din=0, render_go=0, rend_ready=0.
  - Clear counter = 0.
  - Reset asserted mid-clear or mid-render aborts immediately; no further writes are issued.
- All outputs are registered. Write-port latency is one cycle from the accepting edge.
- START (one cycle):
  - clear_en=1 -> CLEAR; latch backdrop into the clear-color register; clear counter = 0.
  - clear_en=0 -> RENDER; render_go=1 in the first RENDER cycle.
- CLEAR:
  - Each cycle: buf_we=1, buf_addr=counter, buf_din=latched color; counter +1.
  - rend_ready=0.
  - After the write at address PIX_COUNT-1 -> RENDER, with render_go pulsed one cycle. A clear takes exactly PIX_COUNT cycles.
- RENDER:
  - rend_ready=1.
  - Accepted pixel: next cycle buf_we=1 with addr/color copied.
  - rend_addr >= PIX_COUNT: write suppressed (buf_we=0), oob_err set.
  - rend_frame_done -> WAIT_VGA. A pixel accepted in the same cycle is still written.
- WAIT_VGA:
  - rend_ready=0.
  - On vga_frame_end: toggle inverts, then -> START.
- Missed swap:
  - vga_frame_end while in CLEAR or RENDER: drop_cnt+1, saturating at 255; toggle unchanged.
  - rend_frame_done and vga_frame_end in the same RENDER cycle: treated as a swap, not a drop. toggle inverts next edge, then -> START.
- Pulses arriving outside their consuming state are ignored: rend_frame_done outside RENDER, vga_frame_end in START.
- clear_en and backdrop are sampled only in START.

Optional Feature:
- Macro: GFX_SWAP_WATCHDOG_EN.
- Defined:
  - A per-frame miss counter (2 bits) increments on each dropped vga_frame_end in CLEAR/RENDER.
  - The third consecutive miss forces a swap: toggle inverts, state -> START (the renderer is restarted via render_go), drop_cnt still increments.
  - The miss counter clears in START.
- Undefined: no miss counter; the controller waits indefinitely for rend_frame_done.

Decomposition:
- Package gfx_dbuf_pkg holds:
  - state enum dbuf_state_t {START, CLEAR, RENDER, WAIT_VGA};
  - PIX_COUNT, ADDR_W and COLOR_W defaults;
  - the color typedef bgr555_t.
- One sub-module: dbuf_addr_counter, a wrapping counter with en/clear/last, sized by ADDR_W and MAX=PIX_COUNT-1, used for clear addressing.

Test Plan:
- Reset, then clear_en=1, backdrop=15'h7C00 -> exactly 38400 consecutive buf_we cycles, addresses 0..38399, data 7C00. Then render_go pulses once and rend_ready=1.
- clear_en=0; renderer writes addr 5 color 15'h001F, then pulses rend_frame_done; vga_frame_end 10 cycles later:
  - buf_addr=5, buf_din=001F with buf_we one cycle after acceptance;
  - toggle goes 0->1 the edge after vga_frame_end;
  - render_go pulses again.
- vga_frame_end ×2 during RENDER, then rend_frame_done, then vga_frame_end -> drop_cnt=2, single toggle flip.
- rend_frame_done and vga_frame_end in the same cycle -> toggle flips, drop_cnt unchanged.
- rend_addr=38400 with rend_valid -> no buf_we, oob_err=1 and stays 1 until reset.
- rst_b=0 for one cycle mid-CLEAR at address 1000 -> buf_we=0 next cycle, toggle=0, state restarts at START.
- Watchdog (with GFX_SWAP_WATCHDOG_EN): three vga_frame_end pulses with no rend_frame_done -> forced toggle flip on the third, drop_cnt=3.

Source files
------------

// File: rtl/gfx_dbuf_pkg.sv
// gfx_dbuf_pkg: shared types and default sizes for the double-buffer
// swap controller.
//   dbuf_state_t : sequencer states (START, CLEAR, RENDER, WAIT_VGA)
//   DEF_*        : default frame size and bus widths (240x160 BGR555)
//   bgr555_t     : one pixel in BGR555 format
package gfx_dbuf_pkg;

  localparam int DEF_PIX_COUNT = 38400;
  localparam int DEF_ADDR_W    = 17;
  localparam int DEF_COLOR_W   = 15;

  typedef enum logic [1:0] {
    START    = 2'd0,
    CLEAR    = 2'd1,
    RENDER   = 2'd2,
    WAIT_VGA = 2'd3
  } dbuf_state_t;

  typedef logic [DEF_COLOR_W-1:0] bgr555_t;

endpackage

// File: rtl/dbuf_addr_counter.sv
// dbuf_addr_counter: wrapping address counter for the backdrop clear.
// Ports:
//   clk, rst_b : clock, synchronous active-low reset
//   en         : advance by one (wraps to 0 after MAX)
//   clear      : synchronous clear to 0 (wins over en)
//   count      : current address
//   last       : count == MAX
module dbuf_addr_counter
  import gfx_dbuf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MAX    = DEF_PIX_COUNT - 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              en,
  input  logic              clear,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  localparam logic [ADDR_W-1:0] MAX_V = ADDR_W'(MAX);

  assign last = (count == MAX_V);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/dbuf_swap_ctrl.sv
// dbuf_swap_ctrl: sequencer for the graphics-side port of the
// double-buffered frame store. Optionally clears the back buffer to a
// backdrop color, lets the renderer draw, then swaps buffers at the
// VGA frame end following the renderer's frame-done pulse.
//
// Optional build macro GFX_SWAP_WATCHDOG_EN: a third consecutive missed
// swap within one frame forces the swap and restarts the renderer.
//
// Ports:
//   clk, rst_b                   : clock, synchronous active-low reset
//   rend_valid/addr/color, ready : renderer pixel stream (valid/ready)
//   rend_frame_done              : renderer finished its frame (pulse)
//   render_go                    : renderer may start a frame (pulse)
//   vga_frame_end                : end of VGA active scan (pulse)
//   clear_en, backdrop           : backdrop clear control, sampled in START
//   buf_addr/din/we              : back-buffer write port (registered)
//   toggle                       : buffer select level
//   drop_cnt                     : saturating count of missed swaps
//   oob_err                      : sticky out-of-range renderer address
module dbuf_swap_ctrl
  import gfx_dbuf_pkg::*;
#(
  parameter int PIX_COUNT = DEF_PIX_COUNT,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int COLOR_W   = DEF_COLOR_W
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               rend_valid,
  input  logic [ADDR_W-1:0]  rend_addr,
  input  logic [COLOR_W-1:0] rend_color,
  output logic               rend_ready,
  input  logic               rend_frame_done,
  output logic               render_go,
  input  logic               vga_frame_end,
  input  logic               clear_en,
  input  logic [COLOR_W-1:0] backdrop,
  output logic [ADDR_W-1:0]  buf_addr,
  output logic [COLOR_W-1:0] buf_din,
  output logic               buf_we,
  output logic               toggle,
  output logic [7:0]         drop_cnt,
  output logic               oob_err
);

  localparam logic [ADDR_W-1:0] PIX_LIM = ADDR_W'(PIX_COUNT);

  dbuf_state_t        state, state_n;
  logic [COLOR_W-1:0] clr_color;
  logic [ADDR_W-1:0]  clr_addr;
  logic               clr_last;
  logic               cnt_en, cnt_clear;
  logic               swap, drop, forced;
`ifdef GFX_SWAP_WATCHDOG_EN
  logic [1:0]         miss_cnt;
`endif

  assign cnt_en    = (state == CLEAR);
  assign cnt_clear = (state == START);

  dbuf_addr_counter #(
    .ADDR_W (ADDR_W),
    .MAX    (PIX_COUNT - 1)
  ) u_clr_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .en    (cnt_en),
    .clear (cnt_clear),
    .count (clr_addr),
    .last  (clr_last)
  );

  always_comb begin
    // A frame end while the back buffer is still being produced is a
    // miss, unless frame-done lands in the same cycle (that is a swap).
    drop = vga_frame_end &&
           ((state == CLEAR) || ((state == RENDER) && !rend_frame_done));
`ifdef GFX_SWAP_WATCHDOG_EN
    forced = drop && (miss_cnt == 2'd2);
`else
    forced = 1'b0;
`endif
    swap = forced ||
           (vga_frame_end &&
            ((state == WAIT_VGA) || ((state == RENDER) && rend_frame_done)));

    state_n = state;
    case (state)
      START:    state_n = clear_en ? CLEAR : RENDER;
      CLEAR:    if (swap) state_n = START;
                else if (clr_last) state_n = RENDER;
      RENDER:   if (swap) state_n = START;
                else if (rend_frame_done) state_n = WAIT_VGA;
      WAIT_VGA: if (swap) state_n = START;
      default:  state_n = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state      <= START;
      toggle     <= 1'b0;
      drop_cnt   <= 8'd0;
      oob_err    <= 1'b0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_din    <= '0;
      render_go  <= 1'b0;
      rend_ready <= 1'b0;
      clr_color  <= '0;
`ifdef GFX_SWAP_WATCHDOG_EN
      miss_cnt   <= 2'd0;
`endif
    end else begin
      state      <= state_n;
      // render_go marks the first cycle of every RENDER visit.
      render_go  <= (state_n == RENDER) && (state != RENDER);
      rend_ready <= (state_n == RENDER);
      buf_we     <= 1'b0;

      if ((state == START) && clear_en)
        clr_color <= backdrop;

      if (state == CLEAR) begin
        buf_we   <= 1'b1;
        buf_addr <= clr_addr;
        buf_din  <= clr_color;
      end else if ((state == RENDER) && rend_valid && rend_ready) begin
        if (rend_addr < PIX_LIM) begin
          buf_we   <= 1'b1;
          buf_addr <= rend_addr;
          buf_din  <= rend_color;
        end else begin
          oob_err <= 1'b1;
        end
      end

      if (swap)
        toggle <= ~toggle;

      if (drop && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;

`ifdef GFX_SWAP_WATCHDOG_EN
      if (state == START)
        miss_cnt <= 2'd0;
      else if (drop)
        miss_cnt <= miss_cnt + 2'd1;
`endif
    end
  end

endmodule
